// File: rtl/sensor_uart_pkg.sv
// Shared definitions for the sensor-to-UART scheduler.
//   SYNC_BYTE     : first byte of every packet
//   PKT_LEN       : bytes per packet (SYNC, CH_ID, MSB, LSB, CSUM)
//   sched_state_e : scheduler FSM states
//   pkt_byte()    : returns byte idx of the packet framed for channel ch and sample
package sensor_uart_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hAA;
  localparam int unsigned PKT_LEN   = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } sched_state_e;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [2:0]  ch,
                                          input logic [15:0] sample);
    logic [7:0] ch_id;
    logic [7:0] res;
    ch_id = {5'b0, ch};
    case (idx)
      3'd0:    res = SYNC_BYTE;
      3'd1:    res = ch_id;
      3'd2:    res = sample[15:8];
      3'd3:    res = sample[7:0];
      3'd4:    res = ch_id ^ sample[15:8] ^ sample[7:0];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Searches req starting at ptr and wrapping modulo N_CH;
// the first set bit wins. No state: the pointer is owned by the caller.
//   req   : request vector
//   ptr   : channel searched first (must be < N_CH)
//   grant : one-hot winner, all zero when req is zero
//   idx   : binary index of the winner, zero when req is zero
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic             found;
    logic [IDX_W:0]   cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      // ptr + k, folded back into 0..N_CH-1 (works for non-power-of-two N_CH)
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_CH)) begin
        cand = cand - (IDX_W + 1)'(N_CH);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sensor_uart_scheduler.sv
// Round-robin scheduler sharing one UART TX channel between N_CH sensor requesters.
// A granted channel's 16-bit sample is latched and sent as a 5-byte packet
// (AA, CH_ID, MSB, LSB, CSUM) using the tx_start/tx_busy/tx_done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request level, held until ack
//   sample     : channel i sample on [16*i+15:16*i]
//   ack        : one-cycle pulse, sample of that channel captured
//   tx_start   : one-cycle pulse, tx_data valid
//   tx_data    : byte being sent, held from tx_start until tx_done
//   tx_busy    : UART transmitter busy
//   tx_done    : UART one-cycle byte-complete pulse
//   busy       : packet in flight
//   err        : one-cycle pulse when a byte times out (packet abandoned)
//   pkt_count  : completed packets, wrapping
module sensor_uart_scheduler
  import sensor_uart_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req,
  input  logic [16*N_CH-1:0]   sample,
  output logic [N_CH-1:0]      ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Timer starts at 0 in the first WAIT cycle, so this value lands TIMEOUT_CYCLES after tx_start
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX = 3'(PKT_LEN - 1);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [15:0]      sample_q, sample_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  ack_q, ack_d;

  logic [N_CH-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [15:0]      arb_sample;
  logic [IDX_W-1:0] next_ptr;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    arb_sample = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (arb_grant[i]) begin
        arb_sample = sample[16*i +: 16];
      end
    end
  end

  // Next search starts just after the channel that was served (or abandoned)
  assign next_ptr = (win_q == IDX_W'(N_CH - 1)) ? '0 : win_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      sample_q   <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      sample_q   <= sample_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    sample_d   = sample_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d      = arb_idx;
          sample_d   = arb_sample;
          ack_d      = arb_grant;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // tx_done takes priority over a timeout landing on the same cycle
        if (tx_done) begin
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + 1'b1;
            ptr_d   = next_ptr;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else if (timer_q == TMR_LAST) begin
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_start = (state_q == SEND) && !tx_busy;
    tx_data  = (state_q == IDLE) ? 8'h00 : pkt_byte(byte_idx_q, 3'(win_q), sample_q);
    busy     = (state_q != IDLE);
    err      = (state_q == WAIT) && !tx_done && (timer_q == TMR_LAST);
  end

  assign ack       = ack_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_sensor_uart_scheduler.sv
module tb_sensor_uart_scheduler;

  localparam int N  = 4;
  localparam int TO = 40;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] sample = '0;
  logic [N-1:0]    ack;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic            tx_done = 1'b0;
  logic            busy;
  logic            err;
  logic [CW-1:0]   pkt_count;

  always #5 clk = ~clk;

  sensor_uart_scheduler #(
    .N_CH           (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sample    (sample),
    .ack       (ack),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .busy      (busy),
    .err       (err),
    .pkt_count (pkt_count)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int first_set(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- UART stub ----------------
  int stub_mode = 0;   // 0: answers each byte, 1: never answers
  int stub_min  = 1;
  int stub_max  = 6;
  bit stray_en  = 1'b0;
  bit seen_start = 1'b0;
  int stub_left = 0;

  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (stub_left > 0) begin
      stub_left--;
      if (stub_left == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end else if (seen_start && stub_mode == 0) begin
      tx_busy   = 1'b1;
      stub_left = $urandom_range(stub_max, stub_min);
    end else if (stray_en && !tx_busy && $urandom_range(63, 0) == 0) begin
      tx_done = 1'b1;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int         m_ptr, m_win, m_wait, m_cnt, m_done_total;
  bit         m_busy, m_sending, m_waiting;
  logic [N-1:0] m_ack_exp;
  logic [7:0] m_bytes[$];

  logic [7:0] rx_log[$];
  int         ack_log[$];
  int         start_cyc, err_cyc, dut_done;
  bit         err_seen;

  task automatic model_reset();
    m_ptr = 0; m_win = 0; m_wait = 0; m_cnt = 0; m_done_total = 0;
    m_busy = 0; m_sending = 0; m_waiting = 0; m_ack_exp = '0;
    m_bytes.delete();
  endtask

  always @(negedge clk) begin
    logic [15:0] s;
    int          w;
    cyc++;
    seen_start = tx_start;
    if (!rst_n) begin
      check("rst_ack", ack, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_pkt_count", pkt_count, 0);
      model_reset();
      dut_done = 0;
    end else begin
      // observations for directed checks
      if (ack != 0) begin ack_log.push_back(first_set(ack)); dut_done = 0; end
      if (tx_start) begin rx_log.push_back(tx_data); start_cyc = cyc; end
      if (err) begin err_seen = 1'b1; err_cyc = cyc; end
      if (tx_done && busy) dut_done++;

      // compare against the model
      check("ack", ack, m_ack_exp);
      check("busy", busy, m_busy);
      check("pkt_count", pkt_count, m_cnt);
      check("tx_start", tx_start, m_sending && !tx_busy);
      check("err", err, m_waiting && m_wait == TO && !tx_done);
      if (tx_start && tx_busy) check("start_while_busy", 1, 0);
      if ((m_sending && !tx_busy) || m_waiting) check("tx_data", tx_data, m_bytes[0]);

      // advance the model by one clock
      m_ack_exp = '0;
      if (!m_busy) begin
        if (req != 0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          s = sample[16*w +: 16];
          m_win = w;
          m_ack_exp = '0;
          m_ack_exp[w] = 1'b1;
          m_busy = 1; m_sending = 1;
          m_bytes = {8'hAA, 8'(w), s[15:8], s[7:0], 8'(w) ^ s[15:8] ^ s[7:0]};
        end
      end else if (m_sending) begin
        if (!tx_busy) begin m_sending = 0; m_waiting = 1; m_wait = 1; end
      end else if (m_waiting) begin
        if (tx_done) begin
          void'(m_bytes.pop_front());
          m_waiting = 0;
          if (m_bytes.size() == 0) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_done_total++;
            m_busy = 0;
            m_ptr = (m_win + 1) % N;
          end else begin
            m_sending = 1;
          end
        end else if (m_wait == TO) begin
          m_busy = 0; m_waiting = 0;
          m_bytes.delete();
          m_ptr = (m_win + 1) % N;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (3) step();
    rst_n = 1'b1;
    ack_log.delete();
    rx_log.delete();
    err_seen = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int k = 0;
    step();
    req = req & ~ack;
    while ((busy || req != 0) && k < budget) begin
      step();
      req = req & ~ack;
      k++;
    end
    if (k >= budget) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_acks(string name, int n, bit drop, int budget);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin
      step();
      if (drop) req = req & ~ack;
      k++;
    end
    check({name, "_ack_count"}, ack_log.size(), n);
  endtask

  task automatic check_pkt(string name, logic [7:0] e0, logic [7:0] e1, logic [7:0] e2,
                           logic [7:0] e3, logic [7:0] e4);
    logic [7:0] e[5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_len"}, rx_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rx_log.size()) check({name, "_byte"}, rx_log[i], e[i]);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit c15, c16;
    model_reset();

    // 1: single request on ch2
    do_reset();
    sample[47:32] = 16'h1234;
    req = 4'b0100;
    step();
    check("t1_ack_latency", ack, 4'b0100);
    req = req & ~ack;
    wait_idle("t1", 400);
    check_pkt("t1_pkt", 8'hAA, 8'h02, 8'h12, 8'h34, 8'h24);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_busy", busy, 0);

    // 2: all four held -> 0,1,2,3,0
    do_reset();
    sample = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req = 4'b1111;
    wait_acks("t2", 5, 1'b0, 1000);
    req = '0;
    wait_idle("t2", 400);
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) check("t2_order", ack_log[i], i % 4);

    // 3: ch1 alone, then ch0|ch1 -> ch0 first after pointer wrap
    do_reset();
    req = 4'b0010;
    wait_idle("t3a", 400);
    req = 4'b0011;
    wait_acks("t3", 3, 1'b1, 1000);
    wait_idle("t3b", 400);
    if (ack_log.size() >= 3) begin
      check("t3_first", ack_log[0], 1);
      check("t3_second", ack_log[1], 0);
      check("t3_third", ack_log[2], 1);
    end

    // 4: UART never answers -> timeout
    do_reset();
    stub_mode = 1;
    req = 4'b0010;
    begin
      int k = 0;
      while (!err_seen && k < 300) begin step(); req = req & ~ack; k++; end
    end
    check("t4_err_seen", err_seen, 1);
    check("t4_err_delay", err_cyc - start_cyc, TO);
    check("t4_busy", busy, 0);
    check("t4_pkt_count", pkt_count, 0);
    check("t4_bytes_sent", rx_log.size(), 1);
    stub_mode = 0;
    rx_log.delete();
    sample[15:0] = 16'h5A5A;
    req = 4'b0001;
    wait_idle("t4", 400);
    check_pkt("t4_restart", 8'hAA, 8'h00, 8'h5A, 8'h5A, 8'h00);

    // 5: reset after 2nd tx_done, UART frame still running
    do_reset();
    stub_min = 8; stub_max = 10;
    sample[47:32] = 16'hCAFE;
    req = 4'b0100;
    begin
      int k = 0;
      while (dut_done < 2 && k < 300) begin step(); req = req & ~ack; k++; end
      check("t5_reach_2nd_done", dut_done, 2);
    end
    step();
    rst_n = 1'b0;
    req = '0;
    repeat (3) step();
    check("t5_ack", ack, 0);
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_busy", busy, 0);
    check("t5_err", err, 0);
    check("t5_pkt_count", pkt_count, 0);
    rst_n = 1'b1;
    rx_log.delete();
    sample[63:48] = 16'hBEEF;
    req = 4'b1000;
    wait_idle("t5", 600);
    check_pkt("t5_pkt", 8'hAA, 8'h03, 8'hBE, 8'hEF, 8'h52);
    stub_min = 1; stub_max = 6;

    // 6: random traffic with stray tx_done, counter wrap
    do_reset();
    stray_en = 1'b1;
    c15 = 1'b0; c16 = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      step();
      req = req & ~ack;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(7, 0) == 0) begin
          sample[16*i +: 16] = 16'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(49, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (m_done_total == 15 && !c15) begin check("t6_count_15", pkt_count, 15); c15 = 1'b1; end
      if (m_done_total == 16 && !c16) begin check("t6_wrap_0", pkt_count, 0); c16 = 1'b1; end
    end
    check("t6_wrap_reached", c16, 1);
    stray_en = 1'b0;
    req = '0;
    wait_idle("t6", 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
